cla_mp_add_seq: RTL and testbench
=================================

Name: cla_mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around a 32-bit carry-lookahead adder datapath.
- Streams WORDS 32-bit limbs, least-significant limb first, through one adder pass per limb.
- Chains the 32-bit carry-out between limbs in a carry register.
- Sits between an operand source (valid/ready stream) and a result sink (valid/ready stream) in the ALU subsystem.

Parameters:
- WORDS, 4, limbs per operation; legal range 1..16.
- CW, 4, limb counter width; must satisfy 2**CW >= WORDS.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- op_sub  in  1  0 = A+B, 1 = A-B; latched at start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand limb valid.
- in_ready  out  1  limb accepted when in_valid & in_ready.
- a_word  in  32  operand A limb.
- b_word  in  32  operand B limb.
- out_valid  out  1  result limb valid.
- out_ready  in  1  sink accepts the result limb.
- sum_word  out  32  result limb.
- out_last  out  1  qualifies the final limb.
- carry_out  out  1  final carry; for subtract, 1 means no borrow.
- overflow  out  1  signed overflow of the full-width result.
- zero  out  1  full-width result is zero (see Optional Feature).
- done  out  1  one-cycle pulse when the operation completes.

Behaviour:
- Reset: asynchronous on rst high. All outputs 0, state IDLE, counter 0, carry register 0, output buffer empty.
- Reset mid-operation aborts immediately; no partial flags are retained.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - On start, latch op_sub, set carry_reg=op_sub, set cnt=0, go to RUN.
  - start is ignored outside IDLE.
- RUN:
  - in_ready = ~out_valid | out_ready (single-entry output buffer; full throughput under no backpressure).
  - Datapath: b_eff = op_sub ? ~b_word : b_word. {c32, s} = a_word + b_eff + carry_reg, computed via 4-bit-group P/G and lookahead carries. Ripple carry is not acceptable.
  - On accept:
    - sum_word <= s, out_valid <= 1, out_last <= (cnt==WORDS-1).
    - carry_reg <= c32, cnt <= cnt+1.
  - On accepting the last limb:
    - carry_out <= c32.
    - overflow <= (a_word[31]==b_eff[31]) & (s[31]!=a_word[31]).
    - Go to FLUSH.
  - Latency: accept to out_valid is 1 cycle.
  - Holding: while out_valid & ~out_ready, sum_word and out_last hold and in_ready=0.
  - Simultaneous: out_ready together with a new accept replaces the buffer in the same cycle; no bubble.
- FLUSH:
  - in_ready=0.
  - When out_valid & out_ready: out_valid <= 0, done <= 1 for one cycle, go to IDLE.
- Flag validity: carry_out, overflow and zero are valid from the cycle done pulses and hold until the next start. At start they clear to 0.
- out_last is 0 whenever out_valid is 0.
- WORDS=1: the first accept goes directly to FLUSH.
- cnt never wraps within an operation.

Optional Feature:
- Macro: CLA_MP_ADD_SEQ_ZERO_FLAG_EN.
- Defined:
  - zero_acc is set to 1 at start.
  - zero_acc <= zero_acc & (s==0) on each accept.
  - zero <= zero_acc & (s==0) on the last accept.
- Undefined: the zero port exists but is tied to 0; no accumulator logic is built.

Decomposition:
- Shared package: state enum (IDLE/RUN/FLUSH), LIMB_W=32, GROUP_W=4, NGROUPS=8.
- One sub-module: cla_add32_lookahead.
  - Inputs: a, b, cin. Outputs: sum, cout.
  - Eight 4-bit group P/G cells plus an 8-group lookahead carry network.
  - Purely combinational.
- The sequencer owns all state.

Test Plan:
- WORDS=4, add. A=0x00000000_00000000_00000000_FFFFFFFF, B=1, no backpressure.
  - Limbs out: 0x00000000, 0x00000001, 0, 0 on 4 consecutive cycles; out_last on the 4th.
  - carry_out=0, overflow=0, done one cycle after the last handshake.
- WORDS=4, subtract, A=B=0x12345678 in every limb.
  - All limbs out are 0; carry_out=1.
  - zero=1 with the macro defined, 0 without.
- WORDS=4, add, A=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1.
  - Result 0x80000000_00000000_00000000_00000000; overflow=1, carry_out=0.
- Backpressure: out_ready=0 for 3 cycles after the first limb.
  - in_ready=0 and sum_word held stable; resumes with no loss or duplication.
- Control corners:
  - start pulsed during RUN is ignored.
  - in_valid=1 in IDLE: in_ready stays 0.
  - rst asserted after limb 2: all outputs 0 in the same cycle, state IDLE; a fresh operation then completes correctly.
- WORDS=1, add, 0xFFFFFFFF+0x00000001 → sum_word=0, out_last=1, carry_out=1, overflow=0.

Source files
------------

// File: rtl/cla_mp_add_seq_pkg.sv
// Shared types, widths and the lookahead carry helper for the multi-precision
// add/subtract sequencer and its 32-bit carry-lookahead adder.
package cla_mp_add_seq_pkg;

    localparam int LIMB_W  = 32;
    localparam int GROUP_W = 4;
    localparam int NGROUPS = LIMB_W / GROUP_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Carry into position n of a lookahead block, written as the flat
    // sum-of-products: c_n = G[n-1] | P[n-1]G[n-2] | ... | P[n-1..0]c0.
    // No term depends on another carry, so no ripple chain is formed.
    function automatic logic carry_into(
        input logic [NGROUPS-1:0] gen,
        input logic [NGROUPS-1:0] prop,
        input logic               c0,
        input int                 n
    );
        logic c;
        logic term;
        // NOTE: function locals are temporaries, so blocking assignments are
        // correct here; registered state elsewhere always uses <=.
        c = c0;
        for (int m = 0; m < NGROUPS; m++) begin
            if (m < n) c = c & prop[m];
        end
        for (int j = 0; j < NGROUPS; j++) begin
            if (j < n) begin
                term = gen[j];
                for (int m = j + 1; m < NGROUPS; m++) begin
                    if (m < n) term = term & prop[m];
                end
                c = c | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_mp_add_seq_if.sv
// Operand and result limb streams of the sequencer (valid/ready on both sides).
// slave: the sequencer; master: the operand source / result sink.
interface cla_mp_add_seq_if
    import cla_mp_add_seq_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [LIMB_W-1:0] a_word;
    logic [LIMB_W-1:0] b_word;
    logic              out_valid;
    logic              out_ready;
    logic [LIMB_W-1:0] sum_word;
    logic              out_last;

    modport slave (
        input  in_valid, a_word, b_word, out_ready,
        output in_ready, out_valid, sum_word, out_last
    );

    modport master (
        output in_valid, a_word, b_word, out_ready,
        input  in_ready, out_valid, sum_word, out_last
    );

endinterface

// File: rtl/cla_mp_add_seq_cla_add32_lookahead.sv
// 32-bit carry-lookahead adder: eight 4-bit P/G cells feeding an 8-group
// lookahead carry network. Purely combinational.
module cla_add32_lookahead
    import cla_mp_add_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    logic [LIMB_W-1:0]  p;
    logic [LIMB_W-1:0]  g;
    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS:0]   grp_c;
    logic [LIMB_W-1:0]  bit_c;

    assign p = a ^ b;
    assign g = a & b;

    for (genvar k = 0; k < NGROUPS; k++) begin : g_cell
        logic [NGROUPS-1:0] cell_g;
        logic [NGROUPS-1:0] cell_p;

        // Widen the 4-bit slice so the shared lookahead helper applies.
        assign cell_g = {{(NGROUPS-GROUP_W){1'b0}}, g[k*GROUP_W +: GROUP_W]};
        assign cell_p = {{(NGROUPS-GROUP_W){1'b0}}, p[k*GROUP_W +: GROUP_W]};

        assign grp_p[k] = &p[k*GROUP_W +: GROUP_W];
        assign grp_g[k] = carry_into(cell_g, cell_p, 1'b0, GROUP_W);

        // Bit carries inside the cell come from the group carry-in.
        for (genvar j = 0; j < GROUP_W; j++) begin : g_bit
            assign bit_c[k*GROUP_W + j] = carry_into(cell_g, cell_p, grp_c[k], j);
        end
    end

    // Group carries all derive directly from cin and the group P/G terms.
    for (genvar n = 0; n <= NGROUPS; n++) begin : g_look
        assign grp_c[n] = carry_into(grp_g, grp_p, cin, n);
    end

    assign sum  = p ^ bit_c;
    assign cout = grp_c[NGROUPS];

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS 32-bit limbs (LS limb
// first) through a carry-lookahead adder, chaining the carry between limbs,
// with a single-entry registered output buffer.
// Optional zero-result flag: define CLA_MP_ADD_SEQ_ZERO_FLAG_EN.
module cla_mp_add_seq
    import cla_mp_add_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int CW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            op_sub,
    output logic            busy,
    cla_mp_add_seq_if.slave bus,
    output logic            carry_out,
    output logic            overflow,
    output logic            zero,
    output logic            done
);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic              carry_reg;
    logic              op_sub_reg;
    logic [LIMB_W-1:0] sum_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              in_ready_c;
    logic [LIMB_W-1:0] b_eff;
    logic [LIMB_W-1:0] s;
    logic              c32;
    logic              start_go;
    logic              accept;
    logic              last_limb;
    logic              out_fire;

    assign b_eff     = op_sub_reg ? ~bus.b_word : bus.b_word;
    assign start_go  = (state == IDLE) && start;
    assign accept    = bus.in_valid && in_ready_c;
    assign last_limb = (cnt == CW'(WORDS - 1));
    assign out_fire  = out_valid_q && bus.out_ready;

    cla_add32_lookahead u_cla (
        .a    (bus.a_word),
        .b    (b_eff),
        .cin  (carry_reg),
        .sum  (s),
        .cout (c32)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next; a missing
        // branch would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start_go)              state_next = RUN;
            RUN:     if (accept && last_limb)   state_next = FLUSH;
            FLUSH:   if (out_fire)              state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Handshake outputs: accept a limb only in RUN when the buffer can take it.
    always_comb begin
        busy       = (state != IDLE);
        in_ready_c = (state == RUN) && (!out_valid_q || bus.out_ready);
    end

    // Limb datapath, carry chain, output buffer and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            carry_reg   <= 1'b0;
            op_sub_reg  <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_go) begin
                op_sub_reg <= op_sub;
                carry_reg  <= op_sub;
                cnt        <= '0;
                carry_out  <= 1'b0;
                overflow   <= 1'b0;
            end
            if (accept) begin
                // A new limb replaces the buffer, even while it is being drained.
                sum_q       <= s;
                out_valid_q <= 1'b1;
                out_last_q  <= last_limb;
                carry_reg   <= c32;
                if (last_limb) begin
                    carry_out <= c32;
                    overflow  <= (bus.a_word[LIMB_W-1] == b_eff[LIMB_W-1]) &&
                                 (s[LIMB_W-1] != bus.a_word[LIMB_W-1]);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                if (state == FLUSH) done <= 1'b1;
            end
        end
    end

`ifdef CLA_MP_ADD_SEQ_ZERO_FLAG_EN
    logic zero_acc;
    logic zero_q;

    // Running "all limbs zero" accumulator, published on the last limb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_acc <= 1'b0;
            zero_q   <= 1'b0;
        end else if (start_go) begin
            zero_acc <= 1'b1;
            zero_q   <= 1'b0;
        end else if (accept) begin
            zero_acc <= zero_acc && (s == '0);
            if (last_limb) zero_q <= zero_acc && (s == '0);
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_word  = sum_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Self-checking bench for cla_mp_add_seq: directed and random operations on a
// 4-limb and a 1-limb instance, checked against a wide-integer reference.
module tb_cla_mp_add_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_mp_add_seq_if bus4 ();
    cla_mp_add_seq_if bus1 ();

    logic start4, op_sub4, busy4, carry4, ovf4, zero4, done4;
    logic start1, op_sub1, busy1, carry1, ovf1, zero1, done1;

    cla_mp_add_seq #(.WORDS(4), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_sub(op_sub4), .busy(busy4),
        .bus(bus4), .carry_out(carry4), .overflow(ovf4), .zero(zero4), .done(done4)
    );

    cla_mp_add_seq #(.WORDS(1), .CW(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .busy(busy1),
        .bus(bus1), .carry_out(carry1), .overflow(ovf1), .zero(zero1), .done(done1)
    );

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic        out_last;
        logic        busy;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        done;
        logic [31:0] sum;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t snap(input int sel);
        obs_t o;
        if (sel == 0) begin
            o = '{bus4.in_ready, bus4.out_valid, bus4.out_last, busy4, carry4, ovf4, zero4, done4, bus4.sum_word};
        end else begin
            o = '{bus1.in_ready, bus1.out_valid, bus1.out_last, busy1, carry1, ovf1, zero1, done1, bus1.sum_word};
        end
        return o;
    endfunction

    task automatic drive(input int sel, input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic st, input logic sub);
        if (sel == 0) begin
            bus4.in_valid = iv; bus4.a_word = a; bus4.b_word = b; bus4.out_ready = ordy;
            start4 = st; op_sub4 = sub;
        end else begin
            bus1.in_valid = iv; bus1.a_word = a; bus1.b_word = b; bus1.out_ready = ordy;
            start1 = st; op_sub1 = sub;
        end
    endtask

    task automatic check_all_zero(input string tag, input int sel);
        obs_t o;
        o = snap(sel);
        check({tag, "_outputs"}, 128'(o), 128'(0));
    endtask

    // mode 0: full rate; 1: out_ready low 3 cycles after first limb;
    // 2: random valid/ready; 3: full rate with a stray start during RUN.
    task automatic run_op(input string name, input int sel, input int nw,
                          input logic [127:0] a_in, input logic [127:0] b_in,
                          input logic sub, input int mode);
        logic [128:0] mask, a, b, bb, full;
        logic [127:0] res;
        logic exp_c, exp_v, exp_z, sa, sb, sr;
        logic iv, ordy, st, hold, hold_last, seen_done;
        logic [31:0] hold_word;
        logic [31:0] got [16];
        logic gl [16];
        int w, idx, nout, cyc, first_out, last_out;
        obs_t o;

        // Reference: whole-operand arithmetic on nw*32-bit integers.
        w    = nw * 32;
        mask = (129'd1 << w) - 129'd1;
        a    = {1'b0, a_in} & mask;
        b    = {1'b0, b_in} & mask;
        bb   = sub ? (~b & mask) : b;
        full = a + bb + 129'(sub);
        res  = full[127:0] & mask[127:0];
        exp_c = full[w];
        sa = a[w-1]; sb = b[w-1]; sr = res[w-1];
        exp_v = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`ifdef CLA_MP_ADD_SEQ_ZERO_FLAG_EN
        exp_z = (res == 128'd0);
`else
        exp_z = 1'b0;
`endif

        idx = 0; nout = 0; cyc = 0; first_out = -1; last_out = -1;
        hold = 0; hold_word = '0; hold_last = 0; seen_done = 0;

        @(negedge clk);
        drive(sel, 1'b0, '0, '0, 1'b1, 1'b1, sub);

        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            iv   = (idx < nw) && (mode != 2 || $urandom_range(3) != 0);
            ordy = (mode == 1) ? !(cyc >= 1 && cyc <= 3) :
                   (mode == 2) ? ($urandom_range(2) != 0) : 1'b1;
            st   = (mode == 3) && (cyc == 1);
            drive(sel, iv, iv ? a[idx*32 +: 32] : 32'd0, iv ? b[idx*32 +: 32] : 32'd0,
                  ordy, st, st ? ~sub : sub);
            #1 o = snap(sel);

            if (cyc == 0) begin
                check({name, "_flags_clear_at_start"}, {o.carry, o.ovf, o.zero}, 3'b000);
                check({name, "_busy_run"}, o.busy, 1'b1);
            end
            if (hold) begin
                check({name, "_hold_word"}, o.sum, hold_word);
                check({name, "_hold_last"}, {o.out_valid, o.out_last}, {1'b1, hold_last});
            end
            if (!o.out_valid) check({name, "_last_qualified"}, o.out_last, 1'b0);
            if (o.out_valid && !ordy) begin
                check({name, "_stall_in_ready"}, o.in_ready, 1'b0);
                hold = 1; hold_word = o.sum; hold_last = o.out_last;
            end else begin
                hold = 0;
            end
            if (o.done) begin
                seen_done = 1;
                check({name, "_done_timing"}, 128'(cyc), 128'(last_out + 1));
                check({name, "_idle_at_done"}, o.busy, 1'b0);
                check({name, "_carry_out"}, o.carry, exp_c);
                check({name, "_overflow"}, o.ovf, exp_v);
                check({name, "_zero"}, o.zero, exp_z);
            end
            if (o.out_valid && ordy) begin
                if (nout == 0) begin
                    first_out = cyc;
                    if (mode == 0 || mode == 3) check({name, "_latency"}, 128'(cyc), 128'(1));
                end else if (mode == 0 || mode == 3) begin
                    check({name, "_full_rate"}, 128'(cyc), 128'(first_out + nout));
                end
                if (nout < 16) begin
                    got[nout] = o.sum;
                    gl[nout]  = o.out_last;
                end
                nout++;
                last_out = cyc;
            end
            if (iv && o.in_ready) idx++;
            cyc++;
        end

        check({name, "_completed"}, seen_done, 1'b1);
        check({name, "_limb_count"}, 128'(nout), 128'(nw));
        for (int i = 0; i < nw && i < nout; i++) begin
            check($sformatf("%s_limb%0d", name, i), got[i], res[i*32 +: 32]);
            check($sformatf("%s_last%0d", name, i), gl[i], (i == nw - 1));
        end

        // done is a single pulse; flags hold afterwards.
        @(negedge clk);
        drive(sel, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        #1 o = snap(sel);
        check({name, "_done_pulse"}, o.done, 1'b0);
        check({name, "_flags_hold"}, {o.carry, o.ovf, o.zero}, {exp_c, exp_v, exp_z});
    endtask

    initial begin
        obs_t o;
        logic [127:0] ra, rb;

        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset4", 0);
        check_all_zero("reset1", 1);
        @(negedge clk);
        rst = 1'b0;
        #1 check_all_zero("after_reset4", 0);

        // in_valid in IDLE is ignored.
        @(negedge clk);
        drive(0, 1'b1, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 o = snap(0);
            check("idle_in_ready", {o.in_ready, o.busy, o.out_valid}, 3'b000);
            @(negedge clk);
        end
        drive(0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        run_op("add_carry", 0, 4, 128'hFFFFFFFF, 128'h1, 1'b0, 0);
        run_op("sub_equal", 0, 4, {4{32'h12345678}}, {4{32'h12345678}}, 1'b1, 0);
        run_op("add_ovf", 0, 4, {32'h7FFFFFFF, {3{32'hFFFFFFFF}}}, 128'h1, 1'b0, 0);
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        run_op("backpressure", 0, 4, ra, rb, 1'b0, 1);
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        run_op("stray_start", 0, 4, ra, rb, 1'b1, 3);

        // Reset in the middle of an operation, after two limbs.
        @(negedge clk);
        drive(0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, $urandom | 32'h1, $urandom, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, $urandom | 32'h1, $urandom, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1 o = snap(0);
        check("pre_reset_busy", {o.busy, o.out_valid}, 2'b11);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_op_reset", 0);
        @(negedge clk);
        rst = 1'b0;
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        run_op("after_abort", 0, 4, ra, rb, 1'b0, 0);

        run_op("w1_add", 1, 1, 128'hFFFFFFFF, 128'h1, 1'b0, 0);
        run_op("w1_sub", 1, 1, 128'h5, 128'h7, 1'b1, 0);

        for (int t = 0; t < 6; t++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            run_op($sformatf("rand4_%0d", t), 0, 4, ra, rb, 1'($urandom_range(1)), 2);
        end
        for (int t = 0; t < 4; t++) begin
            run_op($sformatf("rand1_%0d", t), 1, 1, 128'($urandom), 128'($urandom),
                   1'($urandom_range(1)), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
